// File: rtl/sign_restore_pkg.sv
// -----------------------------------------------------------------------------
// Module : sr_pkg
// Shared constants and the sign-reapply/saturate helper for the sign path.
// Rev    : 1.0 initial release
// -----------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] SMAX = 32'h7FFFFFFF;
  localparam logic [WIDTH_DEF-1:0] SMIN = 32'h80000000;

  // Returns {ovf, data}: the magnitude with its sign restored, clamped to range.
  function automatic logic [WIDTH_DEF:0] sat_apply_sign(input logic sign,
                                                        input logic [WIDTH_DEF-1:0] mag);
    logic [WIDTH_DEF:0] r;
    if (!sign) begin
      if (mag[WIDTH_DEF-1]) r = {1'b1, SMAX};
      else                  r = {1'b0, mag};
    end else begin
      if (mag > SMIN) r = {1'b1, SMIN};
      else            r = {1'b0, (~mag) + {{(WIDTH_DEF-1){1'b0}}, 1'b1}};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sign_restore_if.sv
// -----------------------------------------------------------------------------
// Module : sign_restore_if
// Sign, magnitude and result handshakes plus status for sign_restore.
// Rev    : 1.0 initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface sign_restore_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 3
);
  logic             sgn_valid;
  logic             sgn_in;
  logic             sgn_ready;
  logic             mag_valid;
  logic [WIDTH-1:0] mag_in;
  logic             mag_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             res_ready;
  logic [CNTW-1:0]  fill_count;
  logic             underrun_err;

  // Upstream/downstream environment side.
  modport master (
    output sgn_valid, sgn_in, mag_valid, mag_in, res_ready,
    input  sgn_ready, mag_ready, res_valid, res_data, res_ovf, fill_count, underrun_err
  );

  // sign_restore side.
  modport slave (
    input  sgn_valid, sgn_in, mag_valid, mag_in, res_ready,
    output sgn_ready, mag_ready, res_valid, res_data, res_ovf, fill_count, underrun_err
  );
endinterface

`default_nettype wire

// File: rtl/sign_restore_fifo.sv
// -----------------------------------------------------------------------------
// Module : sign_fifo
// DEPTH-entry, 1-bit wide strict FIFO holding stripped sign bits.
// Rev    : 1.0 initial release
// -----------------------------------------------------------------------------
`default_nettype none

module sign_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == C_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sign_restore.sv
// -----------------------------------------------------------------------------
// Module : sign_restore
// Reapplies queued signs to returning magnitudes with saturation, registered out.
// Rev    : 1.0 initial release
// -----------------------------------------------------------------------------
`default_nettype none

module sign_restore
  import sr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sign_restore_if.slave    bus
);

  logic            fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            push;
  logic            xfer;
  logic [WIDTH:0]  sat;

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             underrun_err;

  // A full FIFO refuses pushes even when a pop is happening in the same cycle.
  assign push          = bus.sgn_valid && !fifo_full;
  assign bus.sgn_ready = !fifo_full;
  assign bus.mag_ready = !fifo_empty && (!res_valid || bus.res_ready);
  assign xfer          = bus.mag_valid && bus.mag_ready;
  assign sat           = sat_apply_sign(fifo_dout, bus.mag_in);

  sign_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (xfer),
    .din   (bus.sgn_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_ovf      <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (xfer) begin
        res_valid <= 1'b1;
        res_ovf   <= sat[WIDTH];
        res_data  <= sat[WIDTH-1:0];
      end else if (bus.res_ready) begin
        res_valid <= 1'b0;
      end
      if (bus.mag_valid && fifo_empty) begin
        underrun_err <= 1'b1;
      end
    end
  end

  assign bus.res_valid    = res_valid;
  assign bus.res_data     = res_data;
  assign bus.res_ovf      = res_ovf;
  assign bus.underrun_err = underrun_err;
  assign bus.fill_count   = fifo_count;

endmodule

`default_nettype wire

// File: tb/tb_sign_restore.sv
// -----------------------------------------------------------------------------
// Module : tb_sign_restore
// Self-checking bench: vector table, corner sequences and randomized model.
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sign_restore;

  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sign_restore_if #(.WIDTH(W), .CNTW(3)) bus ();

  sign_restore #(.WIDTH(W), .DEPTH(D), .CNTW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        sign;
    logic [31:0] mag;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed value of the magnitude, clamped into the 32-bit two's-complement range.
  function automatic logic [32:0] ref_res(input logic s, input logic [31:0] m);
    longint v;
    v = longint'(m);
    if (s) v = -v;
    if (v > 64'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, v[31:0]};
  endfunction

  // Model state for the randomized phase.
  bit          q[$];
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_ovf;
  bit          m_under;

  initial begin
    vecs[0] = '{1'b1, 32'h00185571, 32'hFFE7AA8F, 1'b0};
    vecs[1] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0};
    vecs[3] = '{1'b1, 32'h80000001, 32'h80000000, 1'b1};
    vecs[4] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7] = '{1'b0, 32'h00002000, 32'h00002000, 1'b0};

    bus.sgn_valid = 1'b0;
    bus.sgn_in    = 1'b0;
    bus.mag_valid = 1'b0;
    bus.mag_in    = '0;
    bus.res_ready = 1'b0;

    // Reset state
    tick();
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_ovf", bus.res_ovf, 0);
    check("rst_fill", bus.fill_count, 0);
    check("rst_underrun", bus.underrun_err, 0);
    check("rst_sgn_ready", bus.sgn_ready, 1);
    rst_n = 1'b1;
    tick();

    // Table: push one sign, pair it with a magnitude next cycle, drain.
    for (int i = 0; i < 8; i++) begin
      bus.sgn_valid = 1'b1;
      bus.sgn_in    = vecs[i].sign;
      bus.res_ready = 1'b1;
      tick();
      bus.sgn_valid = 1'b0;
      bus.mag_valid = 1'b1;
      bus.mag_in    = vecs[i].mag;
      #1;
      check("tbl_mag_ready", bus.mag_ready, 1);
      tick();
      bus.mag_valid = 1'b0;
      #1;
      check("tbl_res_valid", bus.res_valid, 1);
      check("tbl_res_data", bus.res_data, vecs[i].exp_data);
      check("tbl_res_ovf", bus.res_ovf, vecs[i].exp_ovf);
      check("tbl_fill", bus.fill_count, 0);
      tick();
      check("tbl_drain", bus.res_valid, 0);
    end

    // Positive pass-through, back-to-back results.
    bus.sgn_valid = 1'b1;
    bus.sgn_in    = 1'b0;
    tick();
    tick();
    bus.sgn_valid = 1'b0;
    #1;
    check("pt_fill2", bus.fill_count, 2);
    bus.mag_valid = 1'b1;
    bus.mag_in    = 32'h00002000;
    bus.res_ready = 1'b1;
    tick();
    check("pt_data0", bus.res_data, 32'h00002000);
    check("pt_fill1", bus.fill_count, 1);
    bus.mag_in = 32'h0021A800;
    tick();
    check("pt_valid1", bus.res_valid, 1);
    check("pt_data1", bus.res_data, 32'h0021A800);
    check("pt_fill0", bus.fill_count, 0);
    bus.mag_valid = 1'b0;
    tick();
    check("pt_drain", bus.res_valid, 0);

    // Fill the FIFO, then attempt a fifth push.
    bus.sgn_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sgn_in = (i != 1);
      tick();
    end
    check("full_fill", bus.fill_count, 4);
    check("full_sgn_ready", bus.sgn_ready, 0);
    bus.sgn_in = 1'b0;
    tick();
    check("full_ignored", bus.fill_count, 4);
    bus.sgn_valid = 1'b0;

    // Backpressure: first result held five cycles.
    bus.res_ready = 1'b0;
    bus.mag_valid = 1'b1;
    bus.mag_in    = 32'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.mag_in = $urandom;
      #1;
      check("bp_mag_ready", bus.mag_ready, 0);
      check("bp_valid", bus.res_valid, 1);
      check("bp_data", bus.res_data, 32'hFFFFFFFB);
      check("bp_fill", bus.fill_count, 3);
      tick();
    end
    bus.res_ready = 1'b1;
    bus.mag_in    = 32'd6;
    tick();
    check("drain_d0", bus.res_data, 32'd6);
    bus.mag_in = 32'd7;
    tick();
    check("drain_d1", bus.res_data, 32'hFFFFFFF9);
    bus.mag_in = 32'd8;
    tick();
    check("drain_d2", bus.res_data, 32'hFFFFFFF8);
    check("drain_fill", bus.fill_count, 0);

    // Underrun: magnitude offered with empty FIFO.
    bus.mag_in = 32'd9;
    #1;
    check("ur_mag_ready", bus.mag_ready, 0);
    check("ur_pre", bus.underrun_err, 0);
    tick();
    check("ur_set", bus.underrun_err, 1);
    check("ur_no_result", bus.res_valid, 0);
    bus.mag_valid = 1'b0;
    tick();
    check("ur_sticky", bus.underrun_err, 1);

    // Reset mid-operation: 3 signs queued and a held result.
    bus.sgn_valid = 1'b1;
    bus.sgn_in    = 1'b0;
    repeat (4) tick();
    bus.sgn_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.mag_valid = 1'b1;
    bus.mag_in    = 32'd3;
    tick();
    bus.mag_valid = 1'b0;
    check("mr_pre_valid", bus.res_valid, 1);
    check("mr_pre_fill", bus.fill_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", bus.res_valid, 0);
    check("mr_data", bus.res_data, 0);
    check("mr_ovf", bus.res_ovf, 0);
    check("mr_fill", bus.fill_count, 0);
    check("mr_underrun", bus.underrun_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.res_ready = 1'b1;
    bus.sgn_valid = 1'b1;
    bus.sgn_in    = 1'b1;
    tick();
    bus.sgn_valid = 1'b0;
    bus.mag_valid = 1'b1;
    bus.mag_in    = 32'h10;
    tick();
    bus.mag_valid = 1'b0;
    check("mr_pair", bus.res_data, 32'hFFFFFFF0);
    check("mr_pair_fill", bus.fill_count, 0);
    tick();

    // Randomized traffic against the queue model.
    m_valid = 0;
    m_data  = '0;
    m_ovf   = 0;
    m_under = 0;
    for (int c = 0; c < 600; c++) begin
      bit sv, sb, mv, rr, e_sr, e_mr, psh, pop;
      logic [31:0] mg;
      logic [32:0] r;
      sv = ($urandom_range(0, 9) < 6);
      sb = $urandom_range(0, 1);
      mv = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0: mg = 32'h0;
        1: mg = 32'h7FFFFFFF;
        2: mg = 32'h80000000;
        3: mg = 32'h80000001;
        4: mg = 32'hFFFFFFFF;
        default: mg = $urandom;
      endcase
      bus.sgn_valid = sv;
      bus.sgn_in    = sb;
      bus.mag_valid = mv;
      bus.mag_in    = mg;
      bus.res_ready = rr;
      #1;
      e_sr = (q.size() != D);
      e_mr = (q.size() != 0) && (!m_valid || rr);
      check("rnd_sgn_ready", bus.sgn_ready, e_sr);
      check("rnd_mag_ready", bus.mag_ready, e_mr);
      check("rnd_res_valid", bus.res_valid, m_valid);
      check("rnd_fill", bus.fill_count, q.size());
      check("rnd_underrun", bus.underrun_err, m_under);
      if (m_valid) begin
        check("rnd_res_data", bus.res_data, m_data);
        check("rnd_res_ovf", bus.res_ovf, m_ovf);
      end
      psh = sv && e_sr;
      pop = mv && e_mr;
      if (mv && q.size() == 0) m_under = 1;
      if (pop) begin
        r       = ref_res(q.pop_front(), mg);
        m_valid = 1;
        m_ovf   = r[32];
        m_data  = r[31:0];
      end else if (rr) begin
        m_valid = 0;
      end
      if (psh) q.push_back(sb);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
